// File: rtl/switch_pkg.sv
// Shared switch types: default field widths, port split constant, FIFO beat layout.
package switch_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    // Addresses at or above ADDR_DIV route to port B, the rest to port A.
    localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_DIV = 8'h80;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } sw_beat_t;

    function automatic logic is_port_b(input logic [DEF_ADDR_WIDTH-1:0] addr);
        return (addr >= ADDR_DIV);
    endfunction

    // Saturating statistics counter step; a clear in the same cycle as an increment leaves 1.
    function automatic logic [31:0] stat_next(input logic [31:0] cur, input logic inc,
                                              input logic clr);
        logic [31:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = {31'd0, inc};
        end else if (inc && (cur != 32'hFFFF_FFFF)) begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/switch_port_buffer_if.sv
// Port-buffer bundle: routed beats in, FIFO head out, occupancy and overflow status.
// Stats counters appear only when SWITCH_PORT_BUF_STATS_EN is defined.
interface switch_port_buffer_if
    import switch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 8,
    localparam int LVL_W     = $clog2(DEPTH + 1)
);

    logic                  in_vld;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [LVL_W-1:0]      level;
    logic                  ovf;
    logic                  ovf_clr;
`ifdef SWITCH_PORT_BUF_STATS_EN
    logic [31:0]           acc_cnt;
    logic [31:0]           drop_cnt;
`endif

    modport master (
        output in_vld, in_addr, in_data, out_rdy, ovf_clr,
`ifdef SWITCH_PORT_BUF_STATS_EN
        input  acc_cnt, drop_cnt,
`endif
        input  out_vld, out_addr, out_data, level, ovf
    );

    modport slave (
        input  in_vld, in_addr, in_data, out_rdy, ovf_clr,
`ifdef SWITCH_PORT_BUF_STATS_EN
        output acc_cnt, drop_cnt,
`endif
        output out_vld, out_addr, out_data, level, ovf
    );

endinterface

// File: rtl/switch_fifo_mem.sv
// FIFO storage: DEPTH beats, one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the edge. No backpressure; no reset on contents.
module switch_fifo_mem
    import switch_pkg::*;
#(
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_ptr_i,
    input  sw_beat_t         wr_beat_i,
    input  logic [PTR_W-1:0] rd_ptr_i,
    output sw_beat_t         rd_beat_o
);

    sw_beat_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_beat_i;
        end
    end

    assign rd_beat_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/switch_port_buffer.sv
// Per-port egress FWFT buffer behind the address switch; drops and flags beats when full.
// Latency: 1 cycle write-to-head. Backpressure: out_rdy only drains; the switch side never stalls.
// SWITCH_PORT_BUF_STATS_EN adds saturating accepted/dropped beat counters.
module switch_port_buffer
    import switch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic clk,
    input  logic rstn,
    switch_port_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  out_vld;
    logic                  push, pop, drop;
    sw_beat_t              wr_beat, rd_beat;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // out_vld comes from the registered level only, so out_rdy cannot loop back into it.
    assign out_vld = (level_q != '0);
    assign pop     = out_vld & bus.out_rdy;
    assign push    = bus.in_vld & ((level_q != LVL_W'(DEPTH)) | pop);
    assign drop    = bus.in_vld & ~push;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_beat.addr = bus.in_addr;
    assign wr_beat.data = bus.in_data;

    switch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_ptr_i  (wptr_q),
        .wr_beat_i (wr_beat),
        .rd_ptr_i  (rptr_q),
        .rd_beat_o (rd_beat)
    );

    // Head is masked to zero while empty so stale storage never leaks out.
    assign head_addr    = out_vld ? rd_beat.addr : '0;
    assign head_data    = out_vld ? rd_beat.data : '0;
    assign bus.out_vld  = out_vld;
    assign bus.out_addr = head_addr;
    assign bus.out_data = head_data;
    assign bus.level    = level_q;
    assign bus.ovf      = ovf_q;

`ifdef SWITCH_PORT_BUF_STATS_EN
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    assign acc_cnt_d  = stat_next(acc_cnt_q, push, bus.ovf_clr);
    assign drop_cnt_d = stat_next(drop_cnt_q, drop, bus.ovf_clr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.acc_cnt  = acc_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_port_buffer.sv
// Randomized scoreboard bench for switch_port_buffer against a queue-based reference FIFO.
module tb_switch_port_buffer;
    import switch_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 8;
    localparam int DW    = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    switch_port_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    switch_port_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    sw_beat_t    model_q[$];
    sw_beat_t    sb_q[$];
    bit          m_ovf;
    logic [31:0] m_acc, m_drop;
    // State the DUT should show between the current edges (model state before this step).
    int          exp_level;
    bit          exp_ovf;
    logic [31:0] exp_acc, exp_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        sb_q.delete();
        m_ovf     = 1'b0;
        m_acc     = '0;
        m_drop    = '0;
        exp_level = 0;
        exp_ovf   = 1'b0;
        exp_acc   = '0;
        exp_drop  = '0;
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and advance the model.
    task automatic step(input bit vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rdy, input bit clr);
        bit       do_pop, do_push, do_drop;
        sw_beat_t b;
        check("missed_pop", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        bus.in_vld  = vld;
        bus.in_addr = a;
        bus.in_data = d;
        bus.out_rdy = rdy;
        bus.ovf_clr = clr;
        exp_level = model_q.size();
        exp_ovf   = m_ovf;
        exp_acc   = m_acc;
        exp_drop  = m_drop;
        do_pop  = (model_q.size() > 0) && rdy;
        do_push = vld && ((model_q.size() < DEPTH) || do_pop);
        do_drop = vld && !do_push;
        if (do_pop) sb_q.push_back(model_q.pop_front());
        if (do_push) begin
            b.addr = a;
            b.data = d;
            model_q.push_back(b);
        end
        if (do_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_acc = {31'd0, do_push};
        else if (do_push && m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 1;
        if (clr) m_drop = {31'd0, do_drop};
        else if (do_drop && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        check("missed_pop", 64'(sb_q.size()), 64'd0);
        rstn        = 1'b0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        bus.ovf_clr = 1'b0;
        model_clear();
        #1;
        check("rst_out_vld", 64'(bus.out_vld), 64'd0);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: sample mid-cycle, compare status every cycle and the head on every handshake.
    always @(negedge clk) begin
        sw_beat_t b;
        check("level", 64'(bus.level), 64'(exp_level));
        check("out_vld", 64'(bus.out_vld), 64'(exp_level != 0));
        check("ovf", 64'(bus.ovf), 64'(exp_ovf));
`ifdef SWITCH_PORT_BUF_STATS_EN
        check("acc_cnt", 64'(bus.acc_cnt), 64'(exp_acc));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
`endif
        if (!bus.out_vld) begin
            check("empty_addr", 64'(bus.out_addr), 64'd0);
            check("empty_data", 64'(bus.out_data), 64'd0);
        end else if (bus.out_rdy && rstn) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%0h/%0h required=none",
                         bus.out_addr, bus.out_data);
            end else begin
                b = sb_q.pop_front();
                check("head_addr", 64'(bus.out_addr), 64'(b.addr));
                check("head_data", 64'(bus.out_data), 64'(b.data));
            end
        end
    end

    initial begin
        bus.in_vld  = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        bus.ovf_clr = 1'b0;
        model_clear();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3, 1'b0);

        // Single beat, then a one-cycle pop.
        step(1'b1, 8'h12, 16'hABCD, 1'b0, 1'b0);
        check("single_head_addr", 64'(bus.out_addr), 64'h12);
        check("single_head_data", 64'(bus.out_data), 64'hABCD);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Fill past full, clear racing a drop, clear, full push+pop, drain.
        for (int i = 0; i < 9; i++) step(1'b1, AW'($urandom), DW'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, AW'($urandom), 16'hDEAD, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, AW'($urandom), 16'h0055, 1'b1, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Streaming through the pointer wrap with address 0 beats mixed in.
        for (int i = 0; i < 20; i++)
            step(1'b1, (i % 4 == 0) ? AW'(0) : AW'($urandom), DW'(i), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Random traffic: a congested phase then a balanced phase.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end
        idle(DEPTH + 2, 1'b1);

        // Reset mid-burst, then a fresh beat must be first out.
        for (int i = 0; i < 5; i++) step(1'b1, AW'($urandom), DW'(16'h100 + i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h3C, 16'h7777, 1'b0, 1'b0);
        check("post_rst_head", 64'(bus.out_data), 64'h7777);
        idle(3, 1'b1);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("model_drained", 64'(model_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
